gps_clken_gen: RTL and testbench

//  Parametrised successor to the GPS clock generator. Produces NUM_CH independent

---
 rtl/gps_clken_gen_if.sv | 18 +
 rtl/gps_clken_gen.sv | 67 ++++++
 tb/tb_gps_clken_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gps_clken_gen_if.sv
// gps_clken_gen_if: config/sync inputs and enable outputs of gps_clken_gen
// master: drives cfg_we/cfg_ch/cfg_div/sync, observes rst_out/ce/clk_div
// slave: the generator side
interface gps_clken_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              sync;
  logic              rst_out;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_div;
  modport master (output cfg_we, cfg_ch, cfg_div, sync, input rst_out, ce, clk_div);
  modport slave  (input cfg_we, cfg_ch, cfg_div, sync, output rst_out, ce, clk_div);
endinterface

// File: rtl/gps_clken_gen.sv
// gps_clken_gen: NUM_CH programmable clock-enable strobes plus a stretched downstream reset
// clk/rst: system clock, sync active-high reset
// bus (slave): cfg_we/cfg_ch/cfg_div write pending ratio, sync realigns, rst_out/ce/clk_div out
module gps_clken_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 4,
  parameter int RST_HOLD = 32,
  parameter int CH_W     = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
  input logic clk,
  input logic rst,
  gps_clken_gen_if.slave bus
);
  localparam int HW = $clog2(RST_HOLD + 1);
  logic          r_rst_out;
  logic [HW-1:0] r_hold;
  logic [NUM_CH-1:0] w_ce, w_clk;
  always_ff @(posedge clk)
    if (rst) begin
      r_rst_out <= 1'b1;
      r_hold    <= '0;
    end else if (r_rst_out) begin
      r_hold    <= r_hold + HW'(1);
      r_rst_out <= r_hold != HW'(RST_HOLD - 1);
    end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt, r_act, r_pend, w_pend, w_dm1;
    logic             r_ce, r_clk, w_we, w_wrap;
    assign w_we   = bus.cfg_we && bus.cfg_ch == CH_W'(g);
    assign w_pend = w_we ? bus.cfg_div : r_pend;
    // ratios 0 and 1 both mean divide-by-one
    assign w_dm1  = r_act == '0 ? '0 : r_act - DIV_W'(1);
    assign w_wrap = r_cnt == w_dm1;
    assign w_ce[g]  = r_ce;
    assign w_clk[g] = r_clk;
    always_ff @(posedge clk)
      if (rst) begin
        r_cnt  <= '0;
        r_act  <= DIV_W'(DEF_DIV);
        r_pend <= DIV_W'(DEF_DIV);
        r_ce   <= 1'b0;
        r_clk  <= 1'b0;
      end else begin
        r_pend <= w_pend;
        if (r_rst_out) begin
          r_cnt <= '0;
          r_ce  <= 1'b0;
          r_clk <= 1'b0;
        end else if (bus.sync) begin
          r_cnt <= '0;
          r_ce  <= 1'b0;
          r_clk <= 1'b0;
          r_act <= w_pend;
        end else begin
          r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
          r_ce  <= w_wrap;
          r_clk <= r_clk ^ w_wrap;
          // new ratio takes effect only at a period boundary
          if (w_wrap) r_act <= w_pend;
        end
      end
  end
  assign bus.rst_out = r_rst_out;
  assign bus.ce      = w_ce;
  assign bus.clk_div = w_clk;
endmodule

// File: tb/tb_gps_clken_gen.sv
// tb_gps_clken_gen: scoreboard bench for gps_clken_gen with three channels
module tb_gps_clken_gen;
  localparam int NC = 3, DW = 16, CW = 2, HOLD = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [6:0] q[$];
  logic [6:0] got, exp_v;
  always #5 clk = ~clk;
  gps_clken_gen_if #(.NUM_CH(NC), .DIV_W(DW), .CH_W(CW)) bus();
  gps_clken_gen #(.NUM_CH(NC), .DIV_W(DW), .DEF_DIV(4), .RST_HOLD(HOLD), .CH_W(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));
  // {ce, clk_div} for a channel whose strobes fall at m = f, f+p, f+2p, ...
  function automatic logic [1:0] ev(int m, int f, int p);
    if (m < f) return 2'b00;
    return {((m - f) % p) == 0, 1'(((m - f) / p + 1) % 2)};
  endfunction
  function automatic logic [6:0] pk(logic ro, logic [1:0] a, logic [1:0] b, logic [1:0] c);
    return {ro, c[1], b[1], a[1], c[0], b[0], a[0]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic we, logic [CW-1:0] ch, logic [DW-1:0] dv, logic sy);
    bus.cfg_we  = we;
    bus.cfg_ch  = ch;
    bus.cfg_div = dv;
    bus.sync    = sy;
  endtask
  task automatic restart;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (HOLD) tick();
  endtask
  task automatic test_reset;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      q.push_back(pk(1, 0, 0, 0));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_state t=%0d got=%b expected=%b", t, got, exp_v);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      q.push_back(pk(e < HOLD, ev(e - HOLD, 4, 4), ev(e - HOLD, 4, 4), ev(e - HOLD, 4, 4)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release e=%0d got=%b expected=%b", e, got, exp_v);
      end
    end
  endtask
  task automatic test_div_update;
    restart();
    for (int m = 1; m <= 40; m++) begin
      drive(m == 2, 0, 10, 0);
      q.push_back(pk(0, ev(m, 4, 10), ev(m, 4, 4), ev(m, 4, 4)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL div_update m=%0d got=%b expected=%b", m, got, exp_v);
      end
    end
  endtask
  task automatic test_div_one;
    restart();
    for (int m = 1; m <= 20; m++) begin
      drive(m <= 2, m == 1 ? 2'd0 : 2'd1, m == 1 ? 16'd0 : 16'd1, 0);
      q.push_back(pk(0, ev(m, 4, 1), ev(m, 4, 1), ev(m, 4, 4)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL div_one m=%0d got=%b expected=%b", m, got, exp_v);
      end
    end
  endtask
  task automatic test_sync;
    restart();
    for (int m = 1; m <= 30; m++) begin
      drive(m == 1 || m == 2 || m == 12, m == 1 ? 2'd0 : m == 2 ? 2'd1 : 2'd2,
            m == 1 ? 16'd3 : m == 2 ? 16'd5 : 16'd6, m == 12);
      if (m < 12) q.push_back(pk(0, ev(m, 4, 3), ev(m, 4, 5), ev(m, 4, 4)));
      else q.push_back(pk(0, ev(m - 12, 3, 3), ev(m - 12, 5, 5), ev(m - 12, 6, 6)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL sync m=%0d got=%b expected=%b", m, got, exp_v);
      end
    end
  endtask
  task automatic test_rst_mid;
    restart();
    for (int t = 1; t <= 77; t++) begin
      drive(t == 1, 0, 7, t == 20);
      rst = (t == 14 || t == 25);
      if (t <= 13) q.push_back(pk(0, ev(t, 4, 7), ev(t, 4, 4), ev(t, 4, 4)));
      else if (t <= 25) q.push_back(pk(1, 0, 0, 0));
      else q.push_back(pk(t - 25 < HOLD, ev(t - 25 - HOLD, 4, 4), ev(t - 25 - HOLD, 4, 4),
                          ev(t - 25 - HOLD, 4, 4)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid t=%0d got=%b expected=%b", t, got, exp_v);
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_cfg_writes;
    restart();
    for (int m = 1; m <= 24; m++) begin
      drive(m <= 3, m == 1 ? 2'd3 : 2'd1, m == 1 ? 16'd7 : m == 2 ? 16'd9 : 16'd6, 0);
      q.push_back(pk(0, ev(m, 4, 4), ev(m, 4, 6), ev(m, 4, 4)));
      tick();
      got = {bus.rst_out, bus.ce, bus.clk_div};
      exp_v = q.pop_front();
      n_chk++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL cfg_writes m=%0d got=%b expected=%b", m, got, exp_v);
      end
    end
  endtask
  initial begin
    test_reset();
    test_div_update();
    test_div_one();
    test_sync();
    test_rst_mid();
    test_cfg_writes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
